// File: rtl/f_ifu_fd.sv
// Fetch PC register and F/D pipeline register with stall/flush control.
// Define F_EXC_EN to add fetch address exception detection (AdEL into D_ExcCode).
module f_ifu_fd #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_TOP   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic [31:0] npc,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic [4:0]  D_ExcCode
);

    logic [31:0] r_f_pc;
    logic [31:0] r_d_pc;
    logic [31:0] r_d_instr;
    logic        r_d_valid;
    logic [4:0]  r_d_exc;
    logic [31:0] r_fetch_cnt;

    logic [31:0] w_f_instr;
    logic [4:0]  w_f_exc;

`ifdef F_EXC_EN
    logic w_bad_addr;
    assign w_bad_addr = (r_f_pc[1:0] != 2'b00) || (r_f_pc < IM_BASE) || (r_f_pc > IM_TOP);
    // A faulting fetch still travels as a valid slot so the exception retires.
    assign w_f_instr  = w_bad_addr ? 32'h0 : i_inst_rdata;
    assign w_f_exc    = w_bad_addr ? 5'd4 : 5'd0;
`else
    assign w_f_instr  = i_inst_rdata;
    assign w_f_exc    = 5'd0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_f_pc <= PC_RESET;
        end else if (flush) begin
            r_f_pc <= flush_pc;
        end else if (!stall) begin
            r_f_pc <= npc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_d_pc      <= PC_RESET;
            r_d_instr   <= 32'h0;
            r_d_valid   <= 1'b0;
            r_d_exc     <= 5'd0;
            r_fetch_cnt <= 32'h0;
        end else if (flush) begin
            r_d_pc    <= flush_pc;
            r_d_instr <= 32'h0;
            r_d_valid <= 1'b0;
            r_d_exc   <= 5'd0;
        end else if (!stall) begin
            r_d_pc      <= r_f_pc;
            r_d_instr   <= w_f_instr;
            r_d_valid   <= 1'b1;
            r_d_exc     <= w_f_exc;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign i_inst_addr = r_f_pc;
    assign F_PC        = r_f_pc;
    assign D_PC        = r_d_pc;
    assign D_instr     = r_d_instr;
    assign D_valid     = r_d_valid;
    assign D_ExcCode   = r_d_exc;

endmodule

// File: tb/tb_f_ifu_fd.sv
// Randomized bench for f_ifu_fd against a cycle-level pipeline model, plus fixed scenarios.
module tb_f_ifu_fd;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_TOP   = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] npc = 32'h0;
    logic [31:0] i_inst_rdata;
    logic [31:0] i_inst_addr;
    logic [31:0] F_PC, D_PC, D_instr;
    logic        D_valid;
    logic [4:0]  D_ExcCode;

    int errors = 0;
    int checks = 0;

    f_ifu_fd #(.PC_RESET(PC_RESET), .IM_BASE(IM_BASE), .IM_TOP(IM_TOP)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .flush_pc(flush_pc), .npc(npc), .i_inst_rdata(i_inst_rdata),
        .i_inst_addr(i_inst_addr), .F_PC(F_PC), .D_PC(D_PC),
        .D_instr(D_instr), .D_valid(D_valid), .D_ExcCode(D_ExcCode)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign i_inst_rdata = mem_word(i_inst_addr);

    function automatic bit bad_addr(input logic [31:0] a);
`ifdef F_EXC_EN
        return (a % 4 != 0) || (a < IM_BASE) || (a > IM_TOP);
`else
        return 1'b0;
`endif
    endfunction

    // Reference model of the fetch PC and the D-stage slot.
    logic [31:0] m_f, m_dpc, m_di, m_cnt;
    logic        m_dv;
    logic [4:0]  m_de;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_f = PC_RESET; m_dpc = PC_RESET; m_di = 0; m_dv = 0; m_de = 0; m_cnt = 0;
        end else if (flush) begin
            m_dpc = flush_pc; m_di = 0; m_dv = 0; m_de = 0;
            m_f = flush_pc;
        end else if (!stall) begin
            m_dpc = m_f;
            m_di  = bad_addr(m_f) ? 32'h0 : mem_word(m_f);
            m_de  = bad_addr(m_f) ? 5'd4 : 5'd0;
            m_dv  = 1'b1;
            m_cnt = m_cnt + 1;
            m_f   = npc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model F_PC", F_PC, m_f);
        check("model i_inst_addr", i_inst_addr, m_f);
        check("model D_PC", D_PC, m_dpc);
        check("model D_instr", D_instr, m_di);
        check("model D_valid", {31'h0, D_valid}, {31'h0, m_dv});
        check("model D_ExcCode", {27'h0, D_ExcCode}, {27'h0, m_de});
        check("model fetch_cnt", dut.r_fetch_cnt, m_cnt);
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2 reset = 1'b1;
        stall = 0; flush = 0;
        #1 check("reset F_PC", F_PC, PC_RESET);
        check("reset D_valid", {31'h0, D_valid}, 32'h0);
        check("reset D_PC", D_PC, PC_RESET);
        check("reset D_instr", D_instr, 32'h0);
        check("reset D_ExcCode", {27'h0, D_ExcCode}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [31:0] exp_pc;

    initial begin
        // Reset then sequential fetch.
        do_reset();
        exp_pc = PC_RESET;
        for (int i = 0; i < 3; i++) begin
            npc = F_PC + 4;
            step();
            exp_pc = exp_pc + 4;
            check("seq F_PC", F_PC, exp_pc);
            check("seq D_PC", D_PC, exp_pc - 4);
            check("seq D_valid", {31'h0, D_valid}, 32'h1);
        end
        check("seq D_instr", D_instr, mem_word(32'h0000_3008));

        // Stall at F_PC=0x3008.
        do_reset();
        npc = 32'h3004; step();
        npc = 32'h3008; step();
        stall = 1; npc = 32'h4000;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall F_PC", F_PC, 32'h3008);
            check("stall D_PC", D_PC, 32'h3004);
        end
        stall = 0;
        step();
        check("unstall F_PC", F_PC, 32'h4000);
        check("unstall D_PC", D_PC, 32'h3008);

        // Simultaneous stall and flush.
        stall = 1; flush = 1; flush_pc = 32'h4180; npc = 32'h5000;
        step();
        stall = 0; flush = 0;
        check("flush F_PC", F_PC, 32'h4180);
        check("flush D_valid", {31'h0, D_valid}, 32'h0);
        check("flush D_instr", D_instr, 32'h0);
        check("flush D_PC", D_PC, 32'h4180);

        // Async reset pulse while stalled.
        npc = 32'h4184; step();
        stall = 1; npc = 32'h5000;
        #2 reset = 1'b1;
        #1 check("midstall rst F_PC", F_PC, PC_RESET);
        check("midstall rst D_valid", {31'h0, D_valid}, 32'h0);
        #1 reset = 1'b0;
        stall = 0;
        npc = 32'h3004;
        step();
        check("post rst D_PC", D_PC, PC_RESET);
        check("post rst D_instr", D_instr, mem_word(PC_RESET));

        // Misaligned and out-of-range fetches.
        npc = 32'h3002; step();
        npc = 32'h7000; step();
        check("exc1 D_PC", D_PC, 32'h3002);
`ifdef F_EXC_EN
        check("exc1 code", {27'h0, D_ExcCode}, 32'd4);
        check("exc1 instr", D_instr, 32'h0);
`else
        check("exc1 code", {27'h0, D_ExcCode}, 32'd0);
        check("exc1 instr", D_instr, mem_word(32'h3002));
`endif
        check("exc1 valid", {31'h0, D_valid}, 32'h1);
        npc = 32'h3000; step();
        check("exc2 D_PC", D_PC, 32'h7000);
`ifdef F_EXC_EN
        check("exc2 code", {27'h0, D_ExcCode}, 32'd4);
`else
        check("exc2 code", {27'h0, D_ExcCode}, 32'd0);
`endif

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            flush_pc = IM_BASE + ($urandom_range(0, 16'h0FFF) << 2);
            if ($urandom_range(0, 9) == 0) npc = $urandom;
            else if ($urandom_range(0, 19) == 0) npc = 32'hFFFF_FFFC;
            else npc = m_f + 4;
            if (i == 300) begin
                do_reset();
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
